// File: rtl/drum_mul_arbiter.sv
// drum_mul_arbiter: round-robin front end sharing one DRUM approximate
// multiplier between NREQ requesters, with a 2-stage registered pipeline
// (S1 = operands, S2 = product) and a single tagged response port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or zero)
//   req_a, req_b             packed operands, requester i at [i*N +: N] / [i*M +: M]
//   rsp_valid/rsp_ready      response handshake, full backpressure
//   rsp_id, rsp_r            requester tag and approximate product
//   busy                     either pipeline stage holds data
module drum_mul_arbiter #(
    parameter int unsigned K    = 6,
    parameter int unsigned N    = 16,
    parameter int unsigned M    = 16,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*M-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [N+M-1:0]      rsp_r,
    output logic                busy
);

    localparam int unsigned RW = N + M;

    // Pipeline state
    logic           v1;
    logic           v2;
    logic [N-1:0]   s1_a;
    logic [M-1:0]   s1_b;
    logic [IDW-1:0] s1_id;
    logic [RW-1:0]  s2_r;
    logic [IDW-1:0] s2_id;
    logic [IDW-1:0] ptr;

    // Flow control
    logic adv1;
    logic adv2;
    logic s1_load;
    logic s2_load;

    // Arbitration
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic [N-1:0]   sel_a;
    logic [M-1:0]   sel_b;

    // DRUM datapath
    int unsigned    lead_a;
    int unsigned    lead_b;
    int unsigned    sh_a;
    int unsigned    sh_b;
    logic [K-1:0]   trunc_a;
    logic [K-1:0]   trunc_b;
    logic [RW-1:0]  prod;
    logic [RW-1:0]  mul_r;

    // Stall chain: a stage may load when it is empty or draining this cycle
    assign adv2    = v2 & rsp_ready;
    assign s2_load = ~v2 | adv2;
    assign adv1    = v1 & s2_load;
    assign s1_load = ~v1 | adv1;

    // Round-robin search from ptr; ready depends only on valid, ptr and stall state
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_ready   = '0;
        if (!rst && s1_load) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                cand = IDW'((32'(ptr) + j) % NREQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
            if (grant_found) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    assign sel_a = req_a[32'(grant_idx)*N +: N];
    assign sel_b = req_b[32'(grant_idx)*M +: M];

    // DRUM: keep K bits from the leading one, force the LSB, then shift back
    always_comb begin
        lead_a = 0;
        lead_b = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (s1_a[i]) lead_a = i;
        end
        for (int unsigned i = 0; i < M; i++) begin
            if (s1_b[i]) lead_b = i;
        end
        sh_a = (lead_a >= K) ? lead_a - (K - 1) : 0;
        sh_b = (lead_b >= K) ? lead_b - (K - 1) : 0;
        if (sh_a == 0) trunc_a = K'(s1_a);
        else           trunc_a = K'(s1_a >> sh_a) | K'(1);
        if (sh_b == 0) trunc_b = K'(s1_b);
        else           trunc_b = K'(s1_b >> sh_b) | K'(1);
        prod  = RW'(trunc_a) * RW'(trunc_b);
        mul_r = prod << (sh_a + sh_b);
    end

    // Stage registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            ptr   <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
            s2_r  <= '0;
            s2_id <= '0;
        end else begin
            if (grant_found) begin
                v1    <= 1'b1;
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= grant_idx;
                ptr   <= (32'(grant_idx) == NREQ - 1) ? '0 : IDW'(32'(grant_idx) + 1);
            end else if (adv1) begin
                v1 <= 1'b0;
            end

            if (adv1) begin
                v2    <= 1'b1;
                s2_r  <= mul_r;
                s2_id <= s1_id;
            end else if (adv2) begin
                v2 <= 1'b0;
            end
        end
    end

    assign rsp_valid = v2;
    assign rsp_id    = s2_id;
    assign rsp_r     = s2_r;
    assign busy      = v1 | v2;

endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Testbench for drum_mul_arbiter: directed known-answer, fairness,
// backpressure, reset and sparse-traffic steps followed by a random phase,
// all checked against a transaction-level model of the arbiter/pipeline.
module tb_drum_mul_arbiter;

    localparam int unsigned K    = 6;
    localparam int unsigned N    = 16;
    localparam int unsigned M    = 16;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a = '0;
    logic [NREQ*M-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [N+M-1:0]      rsp_r;
    logic                busy;

    always #5 clk = ~clk;

    drum_mul_arbiter #(.K(K), .N(N), .M(M), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .busy      (busy)
    );

    // Model: in-flight transactions in acceptance order, each stamped with
    // the edge number at which it was accepted.
    typedef struct {
        int unsigned id;
        logic [31:0] r;
        int unsigned edge_no;
    } item_t;

    item_t       q[$];
    int unsigned ptr_m    = 0;
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand approximation: top K bits from the leading one, LSB forced to 1
    function automatic void approx(input longint unsigned x, output longint unsigned t,
                                   output int unsigned s);
        int unsigned     k;
        longint unsigned v;
        k = 0;
        v = x;
        while (v > 1) begin
            v = v >> 1;
            k++;
        end
        if (k >= K) begin
            s = k - K + 1;
            t = (x >> s) | 64'd1;
        end else begin
            s = 0;
            t = x;
        end
    endfunction

    function automatic logic [31:0] drum_ref(input logic [15:0] a, input logic [15:0] b);
        longint unsigned ta, tb, p;
        int unsigned     sa, sb;
        approx(64'(a), ta, sa);
        approx(64'(b), tb, sb);
        p = (ta * tb) << (sa + sb);
        return p[31:0];
    endfunction

    task automatic set_op(input int unsigned i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*N +: N] = a;
        req_b[i*M +: M] = b;
    endtask

    // One clock cycle: check outputs against the model, cross the edge, update the model
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        logic            exp_v;
        int              g;
        #1;
        exp_v = (q.size() > 0) && (q[0].edge_no < edge_cnt);
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_r", 64'(rsp_r), 64'(q[0].r));
        end
        check("busy", 64'(busy), 64'(q.size() > 0));
        g = -1;
        exp_ready = '0;
        if (!rst && (q.size() < 2 || (exp_v && rsp_ready))) begin
            for (int j = 0; j < int'(NREQ); j++) begin
                int idx;
                idx = (int'(ptr_m) + j) % int'(NREQ);
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (exp_v && rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                item_t it;
                it.id      = g;
                it.r       = drum_ref(req_a[g*N +: N], req_b[g*M +: M]);
                it.edge_no = edge_cnt;
                q.push_back(it);
                ptr_m = (g + 1) % NREQ;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        int unsigned id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] r;
    } kat_t;

    kat_t kat[4];
    int   xfers;
    int unsigned mode;

    initial begin
        kat[0] = '{1, 16'd37,    16'd21,    32'd777};
        kat[1] = '{0, 16'd255,   16'd3,     32'd756};
        kat[2] = '{2, 16'hFFFF,  16'hFFFF,  32'hF8100000};
        kat[3] = '{3, 16'h0000,  16'hFFFF,  32'd0};

        // Initial reset edge (DUT state undefined before it)
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;
        #1;
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_rsp_r", 64'(rsp_r), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Known-answer transactions, one requester at a time
        for (int t = 0; t < 4; t++) begin
            set_op(kat[t].id, kat[t].a, kat[t].b);
            req_valid = NREQ'(1) << kat[t].id;
            step();
            req_valid = '0;
            step();
            #1;
            check("kat_valid", 64'(rsp_valid), 64'd1);
            check("kat_id", 64'(rsp_id), 64'(kat[t].id));
            check("kat_r", 64'(rsp_r), 64'(kat[t].r));
            step();
        end
        step();

        // Fairness: all requesters valid, grants rotate 0,1,2,3,0,...
        for (int i = 0; i < 4; i++) set_op(i, 16'(100 + 37*i), 16'(1000 + 911*i));
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("fair_grant", 64'(req_ready), 64'(1 << (i % 4)));
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure: only two transfers fit while the consumer stalls
        for (int i = 0; i < 3; i++) set_op(i, 16'(300 + 1234*i), 16'(7 + 5000*i));
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ((req_ready & req_valid) != '0) xfers++;
            step();
        end
        check("bp_xfers", 64'(xfers), 64'd2);
        rsp_ready = 1'b1;
        repeat (2) step();
        req_valid = '0;
        repeat (4) step();

        // Reset with both stages full
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '0;
        #1;
        check("rst_mid_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        req_valid = 4'b0110;
        rsp_ready = 1'b1;
        #1;
        check("rst_mid_first_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        repeat (3) step();

        // Sparse traffic: a lone grant to 2 moves the pointer to 3
        set_op(2, 16'd999, 16'd12345);
        req_valid = 4'b0100;
        #1;
        check("sparse_grant2", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        repeat (3) step();
        set_op(0, 16'd4321, 16'd77);
        set_op(3, 16'd65000, 16'd3);
        req_valid = 4'b1001;
        #1;
        check("sparse_grant3_first", 64'(req_ready), 64'b1000);
        step();
        step();
        req_valid = '0;
        repeat (3) step();

        // Random traffic, random backpressure, occasional reset
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                mode = $urandom_range(0, 3);
                case (mode)
                    0: set_op(i, 16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)));
                    1: set_op(i, 16'($urandom), 16'($urandom));
                    2: set_op(i, ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000, 16'($urandom));
                    default: set_op(i, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 4095)));
                endcase
            end
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        check("final_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/drum_mul_arbiter.md
# drum_mul_arbiter

Shared-resource front end for one DRUM approximate multiplier. Up to NREQ independent requesters submit operand pairs over valid/ready handshakes. A round-robin arbiter grants at most one request per cycle. The operands pass through a 2-stage registered pipeline around the combinational approximate multiplier, and each result returns on a single response port tagged with the requester index, with full backpressure.

## Interface
Parameters:
- K, 6, DRUM truncation width (bits kept from each operand, including leading one and forced LSB)
- N, 16, width of operand a
- M, 16, width of operand b
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), width of response tag

Ports (one clock; reset is synchronous, active-high):
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept (one-hot or zero)
- req_a  input  NREQ*N  operand a, requester i at [i*N +: N]
- req_b  input  NREQ*M  operand b, requester i at [i*M +: M]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  IDW  index of requester that issued this result
- rsp_r  output  N+M  approximate product
- busy  output  1  high when either pipeline stage holds data

## Operation
- Arithmetic, per operand x of width W:
  - k = index of leading one; k = 0 when x = 0.
  - If k ≤ K-1: x passes unmodified and shift s = 0.
  - Otherwise: x' = {1, x[k-1 : k-K+2], 1} (K bits) and s = k-K+1.
  - rsp_r = (a'·b') << (s_a + s_b), zero-extended to N+M bits. No rounding and no saturation.
- Stage S1 holds a, b, id and v1. Stage S2 holds r, id and v2.
- adv2 = v2 & rsp_ready. S2 can load when !v2 | adv2.
- adv1 = v1 & (S2 can load). S1 can load when !v1 | adv1.
- Arbitration runs only when S1 can load.
  - Search starts at pointer ptr, ascending modulo NREQ.
  - The first requester i with req_valid[i] gets req_ready[i] = 1. All other req_ready bits are 0.
  - When S1 cannot load, req_ready is all zero.
  - req_ready is combinational from req_valid, ptr and the stall state. It must not depend on req_a or req_b.
- Transfer from requester i occurs when req_valid[i] & req_ready[i]:
  - S1 captures a, b and id = i, and sets v1.
  - ptr becomes (i+1) mod NREQ.
- ptr holds its value in any cycle with no transfer.
- On adv1, S2 captures the approximate product computed from the S1 registers plus the id, and sets v2.
- A valid stage that is not refilled clears its valid bit when it advances.
- rsp_valid = v2, rsp_id = S2 id, rsp_r = S2 r, all directly from registers.
- While rsp_valid is high and rsp_ready is low, rsp_r and rsp_id must hold stable.
- busy = v1 | v2.
- Requesters may change operands or drop req_valid freely before acceptance. The block stores nothing until a transfer occurs.

## Timing
- Reset (rst = 1 at clock edge):
  - v1 = v2 = 0, ptr = 0.
  - Outputs after reset: rsp_valid = 0, rsp_id = 0, rsp_r = 0, busy = 0.
  - req_ready = 0 during any cycle with rst high.
- Reset mid-operation discards both stages. No response is emitted for in-flight requests.
- Latency: a transfer at edge t gives rsp_valid high from edge t+1, i.e. two cycles after the request is presented with ready.
- Throughput is 1 result/cycle while rsp_ready = 1.
- With rsp_ready held 0, at most 2 requests are accepted, then all req_ready bits go 0.
- When rsp_ready returns to 1, a new grant occurs in the same cycle as S2 drains. There are no bubbles.
- Simultaneous requests from all requesters are granted in order ptr, ptr+1, … on consecutive cycles. Each gets one grant per NREQ grants.
- Wrap-around: a grant to NREQ-1 sets ptr = 0.

## Test plan
- Exact path: requester 1 sends a = 37, b = 21 → rsp_r = 777, rsp_id = 1, rsp_valid two edges after acceptance.
- Approximate path: a = 255, b = 3 → rsp_r = 756. Then a = 16'hFFFF, b = 16'hFFFF → rsp_r = 32'hF8100000. Also a = 0, b = 16'hFFFF → rsp_r = 0.
- Fairness: all 4 requesters hold valid with distinct operands from reset → grants 0, 1, 2, 3, 0, … on consecutive cycles. rsp_id follows the same order and each result matches its own operands.
- Backpressure: rsp_ready = 0 with 3 requesters valid → exactly 2 transfers, then req_ready = 0. rsp_r and rsp_id stay stable. Releasing rsp_ready → one response per cycle with no loss, duplication or reordering.
- Reset mid-stream: assert rst while v1 = v2 = 1 → next cycle rsp_valid = 0, busy = 0, ptr = 0. The first post-reset grant goes to the lowest valid index.
- Sparse traffic: a single request from requester 2, followed by idle cycles → ptr = 3. A later simultaneous request from 0 and 3 → 3 is granted first.
